// File: rtl/core_pkg.sv
// Shared constants for the attention-core instruction word and the sequencer state type.
package core_pkg;

    localparam int INST_W    = 20;
    localparam int PR        = 8;

    localparam int SFP_PMEM_WR = 19;
    localparam int ACC         = 18;
    localparam int DIV         = 17;
    localparam int OFIFO_RD    = 16;
    localparam int QKADD_LSB   = 12;
    localparam int PADD_LSB    = 8;
    localparam int MAC_EXE     = 7;
    localparam int MAC_LOAD    = 6;
    localparam int QMEM_RD     = 5;
    localparam int QMEM_WR     = 4;
    localparam int KMEM_RD     = 3;
    localparam int KMEM_WR     = 2;
    localparam int PMEM_RD     = 1;
    localparam int PMEM_WR     = 0;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_QWR  = 4'd1,
        S_KWR  = 4'd2,
        S_KLD  = 4'd3,
        S_KPAD = 4'd4,
        S_EXE  = 4'd5,
        S_DRN  = 4'd6,
        S_ACC  = 4'd7,
        S_DIV  = 4'd8,
        S_FIN  = 4'd9
    } ctrl_state_t;

    // Successor of every phase that simply runs for one row count.
    function automatic ctrl_state_t next_phase(input ctrl_state_t s);
        case (s)
            S_QWR:   return S_KWR;
            S_KWR:   return S_KLD;
            S_KLD:   return S_KPAD;
            S_EXE:   return S_DRN;
            S_ACC:   return S_DIV;
            S_DIV:   return S_FIN;
            default: return S_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/rd_delay_stage.sv
// One-cycle register aligning a MAC load/execute strobe with the SRAM read data it consumes.
module rd_delay_stage (
    input  logic clk,
    input  logic reset,
    input  logic rd_en_i,
    output logic mac_en_o
);

    logic mac_en_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            mac_en_q <= 1'b0;
        end else begin
            mac_en_q <= rd_en_i;
        end
    end

    assign mac_en_o = mac_en_q;

endmodule

// File: rtl/core_inst_ctrl.sv
// Sequencer that walks the attention core through one full Q/K load, MAC and SFP pass per start pulse.
module core_inst_ctrl
    import core_pkg::*;
#(
    parameter int len = 8,
    parameter int col = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              fifo_valid,
    output logic [INST_W-1:0] inst,
    output logic              data_req,
    output logic [3:0]        data_idx,
    output logic              busy,
    output logic              done
);

    localparam int         PAD_W    = $clog2(col + 1);
    localparam logic [3:0] LAST_ROW = 4'(len - 1);
    localparam logic [PAD_W-1:0] PAD_LAST = PAD_W'(col);

    ctrl_state_t       state_q, state_d;
    logic [3:0]        row_q, row_d;
    logic [PAD_W-1:0]  pad_q, pad_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              data_req_q, data_req_d;
    logic [3:0]        data_idx_q, data_idx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rd_issue;
    logic              mac_load;
    logic              mac_exe;

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        pad_d    = pad_q;
        rd_issue = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_QWR;
            end
            S_QWR, S_KWR, S_KLD, S_EXE, S_ACC, S_DIV: begin
                if (row_q == LAST_ROW) begin
                    row_d   = '0;
                    state_d = next_phase(state_q);
                end else begin
                    row_d = row_q + 4'd1;
                end
            end
            // The first pad cycle carries the trailing kernel-load strobe.
            S_KPAD: begin
                if (pad_q == PAD_LAST) begin
                    pad_d   = '0;
                    state_d = S_EXE;
                end else begin
                    pad_d = pad_q + PAD_W'(1);
                end
            end
            // row_q counts reads already presented; fifo_valid seen now yields a read next cycle.
            S_DRN: begin
                if (inst_q[OFIFO_RD] && row_q == LAST_ROW) begin
                    row_d   = '0;
                    state_d = S_ACC;
                end else begin
                    if (inst_q[OFIFO_RD]) row_d = row_q + 4'd1;
                    rd_issue = fifo_valid;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        inst_d = '0;
        case (state_d)
            S_QWR: begin
                inst_d[QMEM_WR]            = 1'b1;
                inst_d[QKADD_LSB +: 4]     = row_d;
            end
            S_KWR: begin
                inst_d[KMEM_WR]            = 1'b1;
                inst_d[QKADD_LSB +: 4]     = row_d;
            end
            S_KLD: begin
                inst_d[KMEM_RD]            = 1'b1;
                inst_d[QKADD_LSB +: 4]     = row_d;
            end
            S_EXE: begin
                inst_d[QMEM_RD]            = 1'b1;
                inst_d[QKADD_LSB +: 4]     = row_d;
            end
            S_DRN: inst_d[OFIFO_RD] = rd_issue;
            S_ACC: inst_d[ACC]      = 1'b1;
            S_DIV: begin
                inst_d[DIV]                = 1'b1;
                inst_d[SFP_PMEM_WR]        = 1'b1;
                inst_d[PMEM_WR]            = 1'b1;
                inst_d[PADD_LSB +: 4]      = row_d;
            end
            default: ;
        endcase
    end

    assign data_req_d = (state_d == S_QWR) || (state_d == S_KWR);
    assign data_idx_d = data_req_d ? row_d : 4'd0;
    assign busy_d     = (state_d != S_IDLE) && (state_d != S_FIN);
    assign done_d     = (state_d == S_FIN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            row_q      <= '0;
            pad_q      <= '0;
            inst_q     <= '0;
            data_req_q <= 1'b0;
            data_idx_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            pad_q      <= pad_d;
            inst_q     <= inst_d;
            data_req_q <= data_req_d;
            data_idx_q <= data_idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    rd_delay_stage u_kld_dly (
        .clk      (clk),
        .reset    (reset),
        .rd_en_i  (inst_q[KMEM_RD]),
        .mac_en_o (mac_load)
    );

    rd_delay_stage u_exe_dly (
        .clk      (clk),
        .reset    (reset),
        .rd_en_i  (inst_q[QMEM_RD]),
        .mac_en_o (mac_exe)
    );

    always_comb begin
        inst           = inst_q;
        inst[MAC_LOAD] = mac_load;
        inst[MAC_EXE]  = mac_exe;
    end

    assign data_req = data_req_q;
    assign data_idx = data_idx_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_core_inst_ctrl.sv
// Bench for core_inst_ctrl: phase-list reference model, two parameterisations (len=8/col=8 and len=1/col=3).
module tb_core_inst_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        st8 = 1'b0, fv8 = 1'b0, st1 = 1'b0, fv1 = 1'b0;
    logic [19:0] inst8, inst1;
    logic        dreq8, dreq1, busy8, busy1, done8, done1;
    logic [3:0]  didx8, didx1;

    core_inst_ctrl #(.len(8), .col(8)) dut8 (
        .clk(clk), .reset(reset), .start(st8), .fifo_valid(fv8),
        .inst(inst8), .data_req(dreq8), .data_idx(didx8), .busy(busy8), .done(done8)
    );

    core_inst_ctrl #(.len(1), .col(3)) dut1 (
        .clk(clk), .reset(reset), .start(st1), .fifo_valid(fv1),
        .inst(inst1), .data_req(dreq1), .data_idx(didx1), .busy(busy1), .done(done1)
    );

    // Observed/expected word: {inst[19:0], data_req, data_idx[3:0], busy, done}
    localparam int WI = 7;

    int          checks = 0;
    int          errors = 0;
    bit          fv_arr [0:299];
    logic [26:0] exp_q [$];
    logic [26:0] obs_q [$];

    function automatic logic [26:0] pk(input int w, input bit req, input int idx, input bit bsy, input bit dn);
        logic [19:0] ww;
        logic [3:0]  ii;
        ww = 20'(w);
        ii = 4'(idx);
        return {ww, req, ii, bsy, dn};
    endfunction

    function automatic logic [26:0] obs(input bit sel);
        return sel ? {inst1, dreq1, didx1, busy1, done1} : {inst8, dreq8, didx8, busy8, done8};
    endfunction

    function automatic bit fv_at(input int q);
        return (q < 300) ? fv_arr[q] : 1'b1;
    endfunction

    // mode 0: always valid; 1: valid every third cycle; 2: random, forced valid late on.
    task automatic fill_fv(input int mode);
        for (int k = 0; k < 300; k++) begin
            if (mode == 0 || k >= 200) fv_arr[k] = 1'b1;
            else if (mode == 1)        fv_arr[k] = (k % 3 == 0);
            else                       fv_arr[k] = bit'($urandom_range(0, 1));
        end
    endtask

    // Expected output for each cycle; index 0 is the cycle in which start is driven.
    task automatic build_expected(input int len, input int col);
        int rds;
        exp_q.delete();
        exp_q.push_back(pk(0, 0, 0, 0, 0));
        for (int i = 0; i < len; i++) exp_q.push_back(pk('h10 | (i << 12), 1, i, 1, 0));
        for (int i = 0; i < len; i++) exp_q.push_back(pk('h04 | (i << 12), 1, i, 1, 0));
        for (int i = 0; i < len; i++) exp_q.push_back(pk('h08 | (i << 12) | (i > 0 ? 'h40 : 0), 0, 0, 1, 0));
        exp_q.push_back(pk('h40, 0, 0, 1, 0));
        for (int i = 0; i < col; i++) exp_q.push_back(pk(0, 0, 0, 1, 0));
        for (int i = 0; i < len; i++) exp_q.push_back(pk('h20 | (i << 12) | (i > 0 ? 'h80 : 0), 0, 0, 1, 0));
        exp_q.push_back(pk('h80, 0, 0, 1, 0));
        rds = 0;
        while (rds < len) begin
            if (fv_at(exp_q.size() - 1)) begin
                exp_q.push_back(pk('h10000, 0, 0, 1, 0));
                rds++;
            end else begin
                exp_q.push_back(pk(0, 0, 0, 1, 0));
            end
        end
        for (int i = 0; i < len; i++) exp_q.push_back(pk('h40000, 0, 0, 1, 0));
        for (int i = 0; i < len; i++) exp_q.push_back(pk('hA0001 | (i << 8), 0, 0, 1, 0));
        exp_q.push_back(pk(0, 0, 0, 0, 1));
        exp_q.push_back(pk(0, 0, 0, 0, 0));
    endtask

    task automatic step(input bit sel, input bit st, input bit fv, input bit rst);
        @(posedge clk);
        #1;
        reset = rst;
        if (sel) begin st1 = st; fv1 = fv; st8 = 1'b0; fv8 = 1'b0; end
        else     begin st8 = st; fv8 = fv; st1 = 1'b0; fv1 = 1'b0; end
        @(negedge clk);
    endtask

    function automatic int count_bit(input int b);
        int n = 0;
        foreach (obs_q[i]) if (obs_q[i][b] === 1'b1) n++;
        return n;
    endfunction

    function automatic int first_bit(input int b);
        foreach (obs_q[i]) if (obs_q[i][b] === 1'b1) return i;
        return -1;
    endfunction

    function automatic int last_bit(input int b);
        int r = -1;
        foreach (obs_q[i]) if (obs_q[i][b] === 1'b1) r = i;
        return r;
    endfunction

    task automatic run_pass(input bit sel, input int len, input int col, input int mode,
                            input int sa, input int sb, input string tag);
        logic [26:0] o;
        fill_fv(mode);
        build_expected(len, col);
        obs_q.delete();
        for (int k = 0; k < exp_q.size(); k++) begin
            step(sel, (k == 0) || (k == sa) || (k == sb), fv_arr[k], 1'b0);
            o = obs(sel);
            obs_q.push_back(o);
            checks++;
            if (o !== exp_q[k]) begin
                errors++;
                $display("FAIL %s cyc=%0d got=%h exp=%h", tag, k, o, exp_q[k]);
            end
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            step(0, 1'b1, 1'b1, 1'b1);
            checks++;
            if (obs(0) !== 27'd0 || obs(1) !== 27'd0) begin
                errors++;
                $display("FAIL reset_state cyc=%0d got=%h/%h exp=0", k, obs(0), obs(1));
            end
        end
        step(0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs(0) !== 27'd0) begin
            errors++;
            $display("FAIL reset_idle got=%h exp=0", obs(0));
        end
    endtask

    task automatic test_basic();
        run_pass(0, 8, 8, 0, -1, -1, "basic");
        checks++;
        if (first_bit(0) !== 67 || count_bit(0) !== 1) begin
            errors++;
            $display("FAIL basic_done at=%0d n=%0d exp at=67 n=1", first_bit(0), count_bit(0));
        end
        checks++;
        if (first_bit(WI + 4) !== 1 || last_bit(WI + 4) !== 8) begin
            errors++;
            $display("FAIL basic_qwr span=%0d..%0d exp 1..8", first_bit(WI + 4), last_bit(WI + 4));
        end
        checks++;
        if (first_bit(WI + 6) !== first_bit(WI + 3) + 1 || count_bit(WI + 6) !== 8) begin
            errors++;
            $display("FAIL align_load first=%0d n=%0d exp first=%0d n=8",
                     first_bit(WI + 6), count_bit(WI + 6), first_bit(WI + 3) + 1);
        end
        checks++;
        if (first_bit(WI + 7) !== first_bit(WI + 5) + 1 || count_bit(WI + 7) !== 8 || first_bit(WI + 5) !== 34) begin
            errors++;
            $display("FAIL align_exe first=%0d n=%0d qrd=%0d exp first=35 n=8 qrd=34",
                     first_bit(WI + 7), count_bit(WI + 7), first_bit(WI + 5));
        end
    endtask

    task automatic test_fifo_stall();
        int tail, lr;
        run_pass(0, 8, 8, 1, -1, -1, "stall");
        lr = last_bit(WI + 16);
        checks++;
        if (count_bit(WI + 16) !== 8 || first_bit(WI + 18) !== lr + 1) begin
            errors++;
            $display("FAIL stall_reads n=%0d acc=%0d exp n=8 acc=%0d", count_bit(WI + 16), first_bit(WI + 18), lr + 1);
        end
        tail = -1;
        foreach (obs_q[i]) if (obs_q[i][26:7] === 20'h00080) tail = i;
        for (int c = tail + 1; c <= lr; c++) begin
            checks++;
            if (obs_q[c][WI + 16] !== fv_arr[c - 1]) begin
                errors++;
                $display("FAIL stall_mirror cyc=%0d got=%b exp=%b", c, obs_q[c][WI + 16], fv_arr[c - 1]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [26:0] o;
        fill_fv(0);
        build_expected(8, 8);
        for (int k = 0; k <= 37; k++) begin
            step(0, k == 0, 1'b1, k == 37);
            o = obs(0);
            checks++;
            if (o !== exp_q[k]) begin
                errors++;
                $display("FAIL mid_pre cyc=%0d got=%h exp=%h", k, o, exp_q[k]);
            end
        end
        checks++;
        if (inst8[15:12] !== 4'd3 || inst8[5] !== 1'b1) begin
            errors++;
            $display("FAIL mid_point add=%0d qrd=%b exp add=3 qrd=1", inst8[15:12], inst8[5]);
        end
        for (int j = 0; j < 6; j++) begin
            step(0, 1'b0, 1'b1, 1'b0);
            checks++;
            if (obs(0) !== 27'd0) begin
                errors++;
                $display("FAIL mid_after cyc=%0d got=%h exp=0", j, obs(0));
            end
        end
        run_pass(0, 8, 8, 0, -1, -1, "post_reset");
        checks++;
        if (count_bit(0) !== 1) begin
            errors++;
            $display("FAIL post_reset_done n=%0d exp=1", count_bit(0));
        end
    endtask

    task automatic test_start_ignored();
        run_pass(0, 8, 8, 0, 10, 67, "restart");
        checks++;
        if (count_bit(0) !== 1 || first_bit(0) !== 67) begin
            errors++;
            $display("FAIL restart_done n=%0d at=%0d exp n=1 at=67", count_bit(0), first_bit(0));
        end
    endtask

    task automatic test_len1();
        int d;
        run_pass(1, 1, 3, 2, -1, -1, "len1");
        d = first_bit(WI + 0);
        checks++;
        if (count_bit(WI + 0) !== 1 || d < 0) begin
            errors++;
            $display("FAIL len1_pmem n=%0d exp=1", count_bit(WI + 0));
        end else begin
            checks++;
            if (obs_q[d][WI + 19] !== 1'b1 || obs_q[d][WI + 17] !== 1'b1 || obs_q[d][WI + 11 -: 4] !== 4'd0) begin
                errors++;
                $display("FAIL len1_div word=%h exp sfp_wr=1 div=1 padd=0", obs_q[d][26:7]);
            end
        end
        checks++;
        if (count_bit(WI + 6) !== 1 || count_bit(WI + 7) !== 1 || count_bit(WI + 4) !== 1 || count_bit(WI + 18) !== 1) begin
            errors++;
            $display("FAIL len1_counts ld=%0d ex=%0d qwr=%0d acc=%0d exp all 1",
                     count_bit(WI + 6), count_bit(WI + 7), count_bit(WI + 4), count_bit(WI + 18));
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) run_pass(0, 8, 8, 2, -1, -1, "rand8");
        for (int r = 0; r < 3; r++) run_pass(1, 1, 3, 2, -1, -1, "rand1");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fifo_stall();
        test_reset_mid();
        test_start_ignored();
        test_len1();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
